dmem_lsu: RTL and testbench
===========================

Name: dmem_lsu

Overview:
- Load/store initiator that drives the word-addressed data memory on behalf of the CPU core.
- Converts byte, halfword and word load/store requests into word-only memory accesses.
  - Sub-word stores use read-modify-write.
  - Loads are sign- or zero-extended.
- Flags misaligned and out-of-range accesses instead of issuing them.
- Sits between the core's memory stage and the data memory.

Parameters:
- MEM_WORDS, 64, number of 32-bit words in the attached data memory. A word index addr[31:2] >= MEM_WORDS is out of range.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  core presents a request.
- req_ready  output  1  LSU can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = reserved.
- req_signed  input  1  sign-extend load result. Ignored for word loads and for stores.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  output  1  response available.
- rsp_ready  input  1  core accepts the response.
- rsp_rdata  output  32  extended load data. 0 for stores and errors.
- rsp_err  output  1  request rejected: misaligned, reserved size, or out of range.
- mem_we  output  1  memory write enable.
- mem_a  output  32  memory byte address, always word-aligned ([1:0] = 0).
- mem_wd  output  32  memory write data.
- mem_rd  input  32  memory read data. Combinational in mem_a; valid in the same cycle.

Behaviour:
- Reset (asynchronous, on reset_n low):
  - State goes to IDLE.
  - req_ready = 1; rsp_valid = 0; rsp_err = 0; rsp_rdata = 0; mem_we = 0; mem_a = 0; mem_wd = 0.
  - Reset mid-operation abandons the request. mem_we drops immediately. No response is produced.
- States: IDLE, READ, WRITE, RESP. req_ready = 1 only in IDLE.
- IDLE:
  - On req_valid & req_ready, latch we/size/signed/addr/wdata.
  - Check, in order:
    - size = 3 is an error.
    - half with addr[0] = 1 is an error.
    - word with addr[1:0] != 0 is an error.
    - addr[31:2] >= MEM_WORDS is an error.
  - On error: go to RESP with rsp_err = 1, rsp_rdata = 0. No memory access.
  - Load or sub-word store: go to READ.
  - Word store: go to WRITE.
- READ:
  - mem_a = {addr[31:2], 2'b00}, mem_we = 0.
  - Capture mem_rd at the clock edge.
  - Load: extract the lane (byte lane = addr[1:0]; half lane = addr[1]), extend, go to RESP.
  - Sub-word store: merge wdata into the captured word at the lane (other bytes unchanged), go to WRITE.
- WRITE:
  - mem_we = 1 for exactly one cycle.
  - mem_a = aligned address.
  - mem_wd = wdata (word store) or the merged word.
  - Go to RESP.
- RESP:
  - rsp_valid = 1. rsp_rdata and rsp_err are held stable until rsp_valid & rsp_ready.
  - Then go to IDLE. rsp_valid = 0 next cycle.
  - A new request is accepted no earlier than the cycle after the handshake.
- Latency (accept edge = T, rsp_ready held 1):
  - Error: rsp_valid at T+1.
  - Load: rsp_valid at T+2.
  - Word store: rsp_valid at T+2.
  - Sub-word store: rsp_valid at T+3.
- mem_we is never high outside WRITE. mem_a holds the last latched aligned address outside READ/WRITE.
- Extension:
  - Signed byte: result = {{24{b[7]}}, b}.
  - Unsigned byte: zero-extend.
  - Halfword: same rules on bit 15.
  - Word: passed unchanged.
- Boundary: address 4*(MEM_WORDS-1)+3 is valid for a byte access. Address 4*MEM_WORDS is out of range.

Test Plan:
- Reset mid-store:
  - Stimulus: byte store to 0x10 in progress; assert reset_n = 0 during WRITE.
  - Response: mem_we falls immediately; no rsp_valid; req_ready = 1 after release; memory word unchanged.
- Signed vs unsigned loads:
  - Stimulus: preload word 0x0 = 0x8000_80F0. Load byte signed at addr 0x0, then unsigned at 0x0, then half signed at 0x2.
  - Response:
    - byte signed: rsp_rdata = 0xFFFF_FFF0.
    - byte unsigned: 0x0000_00F0.
    - half signed: 0xFFFF_8000.
    - Each arrives 2 cycles after accept.
- Sub-word store RMW:
  - Stimulus: word 0x4 = 0x1122_3344; store byte 0xAB to 0x6 (lane 2).
  - Response:
    - READ then WRITE with mem_a = 0x4, mem_wd = 0x11AB_3344.
    - Exactly one mem_we pulse.
    - rsp_valid at T+3, rsp_err = 0.
- Rejected accesses:
  - Stimulus:
    - half load at 0x3;
    - word store at 0x2;
    - size = 3;
    - byte load at 0x100 with MEM_WORDS = 64.
  - Response: each gives rsp_err = 1 and rsp_rdata = 0 at T+1, with mem_we never asserted.
- Response backpressure:
  - Stimulus: word load, hold rsp_ready = 0 for 5 cycles.
  - Response: rsp_valid and rsp_rdata stable throughout; req_ready = 0 until the cycle after the handshake; a second request is accepted then.
- Range boundary:
  - Stimulus: word store 0xDEAD_BEEF to 0xFC, then load it back.
  - Response: write succeeds; load returns 0xDEAD_BEEF.

Source files
------------

// File: rtl/dmem_lsu.sv
// -----------------------------------------------------------------------------
// dmem_lsu
//
// Load/store initiator between the core's memory stage and a word-addressed
// data memory. Byte, halfword and word requests are turned into word-only
// memory accesses:
//   - loads read the containing word, extract the lane and sign- or
//     zero-extend it;
//   - word stores write straight through;
//   - byte/half stores do a read-modify-write of the containing word.
// Misaligned accesses, the reserved size and word indices at or above
// MEM_WORDS are answered with an error response and never reach the memory.
//
// Ports
//   clk, reset_n            clock (rising edge), asynchronous active-low reset
//   req_valid / req_ready   request handshake (ready only while idle)
//   req_we                  1 = store, 0 = load
//   req_size                0 = byte, 1 = half, 2 = word, 3 = reserved
//   req_signed              sign-extend sub-word loads
//   req_addr                byte address
//   req_wdata               right-aligned store data
//   rsp_valid / rsp_ready   response handshake
//   rsp_rdata               extended load data (0 for stores and errors)
//   rsp_err                 request rejected
//   mem_we, mem_a, mem_wd   memory write enable, word-aligned address, data
//   mem_rd                  memory read data, combinational in mem_a
// -----------------------------------------------------------------------------
module dmem_lsu #(
   parameter int MEM_WORDS = 64
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        mem_we,
   output logic [31:0] mem_a,
   output logic [31:0] mem_wd,
   input  logic [31:0] mem_rd
);

   localparam logic [1:0]  SZ_BYTE  = 2'd0;
   localparam logic [1:0]  SZ_HALF  = 2'd1;
   localparam logic [1:0]  SZ_WORD  = 2'd2;
   localparam logic [1:0]  SZ_RSVD  = 2'd3;
   localparam logic [29:0] LP_WORDS = 30'(MEM_WORDS);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_WRITE,
      ST_RESP
   } state_t;

   state_t      r_state;
   logic        r_we;
   logic [1:0]  r_size;
   logic        r_signed;
   logic [1:0]  r_lane;
   logic [31:0] r_wdata;

   logic        r_req_ready;
   logic        r_rsp_valid;
   logic        r_rsp_err;
   logic [31:0] r_rsp_rdata;
   logic        r_mem_we;
   logic [31:0] r_mem_a;
   logic [31:0] r_mem_wd;

   logic        w_accept;
   logic        w_err;
   logic        w_word_store;

   // Pick the addressed lane out of a memory word and extend it to 32 bits.
   function automatic logic [31:0] f_extract(input logic [31:0] word,
                                             input logic [1:0]  size,
                                             input logic        sgn,
                                             input logic [1:0]  lane);
      logic [7:0]  v_b;
      logic [15:0] v_h;
      logic [31:0] v_res;
      case (lane)
         2'd0:    v_b = word[7:0];
         2'd1:    v_b = word[15:8];
         2'd2:    v_b = word[23:16];
         default: v_b = word[31:24];
      endcase
      v_h = lane[1] ? word[31:16] : word[15:0];
      case (size)
         SZ_BYTE: v_res = {{24{sgn & v_b[7]}}, v_b};
         SZ_HALF: v_res = {{16{sgn & v_h[15]}}, v_h};
         default: v_res = word;
      endcase
      return v_res;
   endfunction

   // Overlay right-aligned store data onto the addressed lane of a word,
   // leaving every other byte untouched.
   function automatic logic [31:0] f_merge(input logic [31:0] word,
                                           input logic [31:0] wdata,
                                           input logic [1:0]  size,
                                           input logic [1:0]  lane);
      logic [31:0] v_res;
      v_res = word;
      case (size)
         SZ_BYTE: begin
            case (lane)
               2'd0:    v_res[7:0]   = wdata[7:0];
               2'd1:    v_res[15:8]  = wdata[7:0];
               2'd2:    v_res[23:16] = wdata[7:0];
               default: v_res[31:24] = wdata[7:0];
            endcase
         end
         SZ_HALF: begin
            if (lane[1]) v_res[31:16] = wdata[15:0];
            else         v_res[15:0]  = wdata[15:0];
         end
         default: v_res = wdata;
      endcase
      return v_res;
   endfunction

   assign w_accept     = req_valid & r_req_ready;
   assign w_word_store = req_we & (req_size == SZ_WORD);

   // Request legality, evaluated in priority order on the live request.
   always_comb begin
      w_err = 1'b0;
      if (req_size == SZ_RSVD)
         w_err = 1'b1;
      else if ((req_size == SZ_HALF) && req_addr[0])
         w_err = 1'b1;
      else if ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
         w_err = 1'b1;
      else if (req_addr[31:2] >= LP_WORDS)
         w_err = 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_we        <= 1'b0;
         r_size      <= SZ_BYTE;
         r_signed    <= 1'b0;
         r_lane      <= 2'd0;
         r_wdata     <= 32'd0;
         r_req_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_rdata <= 32'd0;
         r_mem_we    <= 1'b0;
         r_mem_a     <= 32'd0;
         r_mem_wd    <= 32'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_req_ready <= 1'b0;
                  r_we        <= req_we;
                  r_size      <= req_size;
                  r_signed    <= req_signed;
                  r_lane      <= req_addr[1:0];
                  r_wdata     <= req_wdata;
                  r_rsp_rdata <= 32'd0;
                  if (w_err) begin
                     // Rejected requests never touch the memory port, so an
                     // out-of-range address is not placed on mem_a.
                     r_rsp_err   <= 1'b1;
                     r_rsp_valid <= 1'b1;
                     r_state     <= ST_RESP;
                  end else begin
                     r_rsp_err <= 1'b0;
                     r_mem_a   <= {req_addr[31:2], 2'b00};
                     if (w_word_store) begin
                        r_mem_wd <= req_wdata;
                        r_mem_we <= 1'b1;
                        r_state  <= ST_WRITE;
                     end else begin
                        r_state <= ST_READ;
                     end
                  end
               end
            end

            ST_READ: begin
               // mem_rd is combinational in mem_a, already driven this cycle.
               if (r_we) begin
                  r_mem_wd <= f_merge(mem_rd, r_wdata, r_size, r_lane);
                  r_mem_we <= 1'b1;
                  r_state  <= ST_WRITE;
               end else begin
                  r_rsp_rdata <= f_extract(mem_rd, r_size, r_signed, r_lane);
                  r_rsp_valid <= 1'b1;
                  r_state     <= ST_RESP;
               end
            end

            ST_WRITE: begin
               r_mem_we    <= 1'b0;
               r_rsp_valid <= 1'b1;
               r_state     <= ST_RESP;
            end

            ST_RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_req_ready <= 1'b1;
                  r_state     <= ST_IDLE;
               end
            end

            default: begin
               r_mem_we    <= 1'b0;
               r_rsp_valid <= 1'b0;
               r_req_ready <= 1'b1;
               r_state     <= ST_IDLE;
            end
         endcase
      end
   end

   assign req_ready = r_req_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_err   = r_rsp_err;
   assign rsp_rdata = r_rsp_rdata;
   assign mem_we    = r_mem_we;
   assign mem_a     = r_mem_a;
   assign mem_wd    = r_mem_wd;

endmodule

// File: tb/tb_dmem_lsu.sv
// -----------------------------------------------------------------------------
// tb_dmem_lsu
//
// Directed bench for dmem_lsu with a 64-word behavioural memory. Inputs are
// driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_dmem_lsu;

   logic        clk     = 1'b0;
   logic        reset_n = 1'b1;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        mem_we;
   logic [31:0] mem_a;
   logic [31:0] mem_wd;
   logic [31:0] mem_rd;

   logic [31:0] mem [0:63];
   int          n_we    = 0;
   logic [31:0] last_wa = 32'd0;
   logic [31:0] last_wd = 32'd0;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   dmem_lsu #(.MEM_WORDS(64)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .mem_we     (mem_we),
      .mem_a      (mem_a),
      .mem_wd     (mem_wd),
      .mem_rd     (mem_rd)
   );

   // Word-addressed memory: combinational read, write on rising edge.
   assign mem_rd = mem[mem_a[7:2]];

   always @(posedge clk) begin
      if (mem_we) begin
         mem[mem_a[7:2]] <= mem_wd;
         n_we    <= n_we + 1;
         last_wa <= mem_a;
         last_wd <= mem_wd;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Present one request at the current falling edge, wait (bounded) for the
   // response, and complete the handshake if rsp_ready is high.
   task automatic do_req(input logic we, input logic [1:0] sz, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] rd, output logic err, output int lat);
      req_valid  = 1'b1;
      req_we     = we;
      req_size   = sz;
      req_signed = sgn;
      req_addr   = addr;
      req_wdata  = wd;
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      rd  = rsp_rdata;
      err = rsp_err;
      if (rsp_ready) @(negedge clk);
   endtask

   task automatic xact(input string tag, input logic we, input logic [1:0] sz,
                       input logic sgn, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
      logic [31:0] rd;
      logic        err;
      int          lat;
      do_req(we, sz, sgn, addr, wd, rd, err, lat);
      chk({tag, "_rdata"}, rd, exp_rd);
      chk({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
      chk({tag, "_lat"}, lat, exp_lat);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          w0;
      logic [31:0] rd;
      logic        err;
      int          lat;

      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_size   = 2'd0;
      req_signed = 1'b0;
      req_addr   = 32'd0;
      req_wdata  = 32'd0;
      rsp_ready  = 1'b1;

      // Reset values
      #1 reset_n = 1'b0;
      #2;
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rsp_err",   {31'd0, rsp_err},   32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      chk("rst_mem_we",    {31'd0, mem_we},    32'd0);
      chk("rst_mem_a",     mem_a,  32'd0);
      chk("rst_mem_wd",    mem_wd, 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // Preload through word stores
      xact("pre0", 1'b1, 2'd2, 1'b0, 32'h0000_0000, 32'h8000_80F0, 32'd0, 1'b0, 2);
      xact("pre1", 1'b1, 2'd2, 1'b0, 32'h0000_0004, 32'h1122_3344, 32'd0, 1'b0, 2);
      xact("pre4", 1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'h5566_7788, 32'd0, 1'b0, 2);
      chk("pre0_mem", mem[0], 32'h8000_80F0);
      chk("pre0_wd",  last_wd, 32'h5566_7788);

      // Signed and unsigned loads of word 0 = 0x8000_80F0
      xact("lb_s0",  1'b0, 2'd0, 1'b1, 32'h0, 32'd0, 32'hFFFF_FFF0, 1'b0, 2);
      xact("lbu0",   1'b0, 2'd0, 1'b0, 32'h0, 32'd0, 32'h0000_00F0, 1'b0, 2);
      xact("lh_s2",  1'b0, 2'd1, 1'b1, 32'h2, 32'd0, 32'hFFFF_8000, 1'b0, 2);
      xact("lhu2",   1'b0, 2'd1, 1'b0, 32'h2, 32'd0, 32'h0000_8000, 1'b0, 2);
      xact("lb_s1",  1'b0, 2'd0, 1'b1, 32'h1, 32'd0, 32'hFFFF_FF80, 1'b0, 2);
      xact("lb_s2",  1'b0, 2'd0, 1'b1, 32'h2, 32'd0, 32'h0000_0000, 1'b0, 2);
      xact("lh_s0",  1'b0, 2'd1, 1'b1, 32'h0, 32'd0, 32'hFFFF_80F0, 1'b0, 2);
      xact("lw0",    1'b0, 2'd2, 1'b1, 32'h0, 32'd0, 32'h8000_80F0, 1'b0, 2);

      // Rejected accesses: no memory write, zero data, one-cycle latency
      w0 = n_we;
      xact("e_half",  1'b0, 2'd1, 1'b0, 32'h0000_0003, 32'd0,        32'd0, 1'b1, 1);
      xact("e_word",  1'b1, 2'd2, 1'b0, 32'h0000_0002, 32'hCAFE_F00D, 32'd0, 1'b1, 1);
      xact("e_rsvd",  1'b0, 2'd3, 1'b0, 32'h0000_0000, 32'd0,        32'd0, 1'b1, 1);
      xact("e_range", 1'b0, 2'd0, 1'b0, 32'h0000_0100, 32'd0,        32'd0, 1'b1, 1);
      xact("e_strng", 1'b1, 2'd0, 1'b0, 32'h0000_0100, 32'h0000_00AA, 32'd0, 1'b1, 1);
      chk("e_no_we", n_we - w0, 32'd0);

      // Sub-word store read-modify-write on word 1 = 0x1122_3344
      w0 = n_we;
      xact("sb6", 1'b1, 2'd0, 1'b0, 32'h0000_0006, 32'h1234_56AB, 32'd0, 1'b0, 3);
      chk("sb6_pulses", n_we - w0, 32'd1);
      chk("sb6_wa",     last_wa, 32'h0000_0004);
      chk("sb6_wd",     last_wd, 32'h11AB_3344);
      chk("sb6_mem",    mem[1],  32'h11AB_3344);
      xact("sh6", 1'b1, 2'd1, 1'b1, 32'h0000_0006, 32'hFFFF_BEEF, 32'd0, 1'b0, 3);
      chk("sh6_mem",    mem[1],  32'hBEEF_3344);
      xact("sb4", 1'b1, 2'd0, 1'b0, 32'h0000_0004, 32'h0000_0155, 32'd0, 1'b0, 3);
      chk("sb4_mem",    mem[1],  32'hBEEF_3355);

      // Response backpressure on a word load of 0xBEEF_3355
      rsp_ready = 1'b0;
      do_req(1'b0, 2'd2, 1'b0, 32'h0000_0004, 32'd0, rd, err, lat);
      chk("bp_lat", lat, 32'd2);
      chk("bp_rd",  rd,  32'hBEEF_3355);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_hold_valid", {31'd0, rsp_valid}, 32'd1);
         chk("bp_hold_rdata", rsp_rdata, 32'hBEEF_3355);
         chk("bp_hold_ready", {31'd0, req_ready}, 32'd0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_after_valid", {31'd0, rsp_valid}, 32'd0);
      chk("bp_after_ready", {31'd0, req_ready}, 32'd1);
      xact("bp_next", 1'b0, 2'd0, 1'b0, 32'h0000_0007, 32'd0, 32'h0000_00BE, 1'b0, 2);

      // Range boundary: last word
      xact("st_fc", 1'b1, 2'd2, 1'b0, 32'h0000_00FC, 32'hDEAD_BEEF, 32'd0, 1'b0, 2);
      chk("st_fc_mem", mem[63], 32'hDEAD_BEEF);
      xact("ld_fc",  1'b0, 2'd2, 1'b0, 32'h0000_00FC, 32'd0, 32'hDEAD_BEEF, 1'b0, 2);
      xact("lb_ff",  1'b0, 2'd0, 1'b1, 32'h0000_00FF, 32'd0, 32'hFFFF_FFDE, 1'b0, 2);
      xact("lbu_ff", 1'b0, 2'd0, 1'b0, 32'h0000_00FF, 32'd0, 32'h0000_00DE, 1'b0, 2);

      // Reset in the WRITE cycle of a byte store to 0x10
      w0 = n_we;
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_size   = 2'd0;
      req_signed = 1'b0;
      req_addr   = 32'h0000_0010;
      req_wdata  = 32'h0000_0099;
      @(negedge clk);
      req_valid = 1'b0;
      chk("mid_read_we", {31'd0, mem_we}, 32'd0);
      @(negedge clk);
      chk("mid_write_we", {31'd0, mem_we}, 32'd1);
      #1 reset_n = 1'b0;
      #1;
      chk("mid_we_drop",   {31'd0, mem_we},    32'd0);
      chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("mid_post_valid", {31'd0, rsp_valid}, 32'd0);
         chk("mid_post_ready", {31'd0, req_ready}, 32'd1);
      end
      chk("mid_mem",    mem[4],    32'h5566_7788);
      chk("mid_pulses", n_we - w0, 32'd0);
      xact("mid_reload", 1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'd0, 32'h5566_7788, 1'b0, 2);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
